// File: rtl/rv_mcycle_seq.sv
// Multi-cycle in-order fetch/execute/memory/writeback sequencer with per-state
// bus timeout. Request valids and retire pulses are decoded from the state register.
module rv_mcycle_seq #(
  parameter int                WIDTH    = 32,
  parameter logic [WIDTH-1:0]  RESET_PC = 32'h8000_0000,
  parameter int                MAX_WAIT = 16
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_rsp_valid,
  input  logic [WIDTH-1:0] imem_rsp_data,
  input  logic             dec_is_load,
  input  logic             dec_is_store,
  input  logic             dec_rf_wen,
  input  logic [WIDTH-1:0] ex_next_pc,
  output logic             dmem_req_valid,
  output logic             dmem_req_we,
  input  logic             dmem_req_ready,
  input  logic             dmem_rsp_valid,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] inst,
  output logic             rf_wen,
  output logic             retire,
  output logic [WIDTH-1:0] instret,
  output logic             bus_err,
  output logic [2:0]       state
);

  localparam logic [2:0] IF_REQ   = 3'd0;
  localparam logic [2:0] IF_WAIT  = 3'd1;
  localparam logic [2:0] EX       = 3'd2;
  localparam logic [2:0] MEM_REQ  = 3'd3;
  localparam logic [2:0] MEM_WAIT = 3'd4;
  localparam logic [2:0] WB       = 3'd5;
  localparam logic [2:0] ERR      = 3'd6;

  localparam int             CW   = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0]  WLIM = CW'(MAX_WAIT - 1);

  typedef struct packed {
    logic [WIDTH-1:0] next_pc;
    logic             is_store;
    logic             rf_wen;
  } ex_lat_t;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] wcnt;
  ex_lat_t       ex_q;
  logic          waiting, timeout;

  assign waiting = (state_q == IF_REQ) || (state_q == IF_WAIT) ||
                   (state_q == MEM_REQ) || (state_q == MEM_WAIT);
  assign timeout = (wcnt == WLIM);

  // A handshake in the last allowed cycle takes priority over the timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IF_REQ:   if (imem_req_ready)      state_d = IF_WAIT;
                else if (timeout)        state_d = ERR;
      IF_WAIT:  if (imem_rsp_valid)      state_d = EX;
                else if (timeout)        state_d = ERR;
      EX:       state_d = (dec_is_load | dec_is_store) ? MEM_REQ : WB;
      MEM_REQ:  if (dmem_req_ready)      state_d = MEM_WAIT;
                else if (timeout)        state_d = ERR;
      MEM_WAIT: if (dmem_rsp_valid)      state_d = WB;
                else if (timeout)        state_d = ERR;
      WB:       state_d = IF_REQ;
      default:  state_d = ERR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IF_REQ;
      wcnt    <= '0;
      pc      <= RESET_PC;
      inst    <= '0;
      instret <= '0;
      ex_q    <= '0;
    end else begin
      state_q <= state_d;
      if ((state_d != state_q) || !waiting) wcnt <= '0;
      else                                  wcnt <= wcnt + CW'(1);
      if ((state_q == IF_WAIT) && imem_rsp_valid) inst <= imem_rsp_data;
      if (state_q == EX) ex_q <= '{next_pc: ex_next_pc, is_store: dec_is_store, rf_wen: dec_rf_wen};
      if (state_q == WB) begin
        pc      <= ex_q.next_pc;
        instret <= instret + WIDTH'(1);
      end
    end
  end

  // Gating with rst keeps pulses/valids low for the whole reset window.
  assign imem_req_valid = rst && (state_q == IF_REQ);
  assign imem_addr      = pc;
  assign dmem_req_valid = rst && (state_q == MEM_REQ);
  assign dmem_req_we    = rst && (state_q == MEM_REQ) && ex_q.is_store;
  assign retire         = rst && (state_q == WB);
  assign rf_wen         = rst && (state_q == WB) && ex_q.rf_wen && !ex_q.is_store;
  assign bus_err        = (state_q == ERR);
  assign state          = state_q;

endmodule

// File: tb/tb_rv_mcycle_seq.sv
// Directed bench for rv_mcycle_seq: retire scoreboard plus latency, timeout and reset checks.
module tb_rv_mcycle_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        dec_is_load, dec_is_store, dec_rf_wen;
  logic [31:0] ex_next_pc;
  logic        dmem_req_valid, dmem_req_we, dmem_req_ready, dmem_rsp_valid;
  logic [31:0] pc, inst, instret;
  logic        rf_wen, retire, bus_err;
  logic [2:0]  state;

  rv_mcycle_seq #(.WIDTH(32), .RESET_PC(32'h8000_0000), .MAX_WAIT(16)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .dec_is_load(dec_is_load), .dec_is_store(dec_is_store), .dec_rf_wen(dec_rf_wen),
    .ex_next_pc(ex_next_pc),
    .dmem_req_valid(dmem_req_valid), .dmem_req_we(dmem_req_we),
    .dmem_req_ready(dmem_req_ready), .dmem_rsp_valid(dmem_rsp_valid),
    .pc(pc), .inst(inst), .rf_wen(rf_wen), .retire(retire), .instret(instret),
    .bus_err(bus_err), .state(state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passes = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  typedef struct {
    logic [31:0] pc;
    logic        wen;
    logic [31:0] instret;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  logic        pend = 1'b0;
  int          last_ret = 0;
  int          prev_ret = 0;
  logic [31:0] exp_ir = 0;

  // Retire monitor: WB-cycle fields now, architectural state one cycle later.
  always @(negedge clk) begin
    if (pend) begin
      chk("pc_after_wb", pc, cur.pc);
      chk("instret_after_wb", instret, cur.instret);
      pend = 1'b0;
    end
    if (rst && retire) begin
      if (sb.size() == 0) chk("unexpected_retire", {31'b0, retire}, 32'd0);
      else begin
        cur = sb.pop_front();
        chk("rf_wen_wb", {31'b0, rf_wen}, {31'b0, cur.wen});
        pend = 1'b1;
      end
      prev_ret = last_ret;
      last_ret = cyc;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_inst(input logic [31:0] addr, input logic [31:0] data,
                         input logic ld, input logic st, input logic wen,
                         input logic [31:0] npc, input int if_dly, input int mem_dly,
                         input logic early_rsp);
    int n;
    imem_req_ready = 1'b1; imem_rsp_valid = early_rsp; imem_rsp_data = ~data;
    @(negedge clk);
    chk("if_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("if_addr", imem_addr, addr);
    tick();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
    for (int i = 0; i < if_dly; i++) tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = data;
    tick();
    imem_rsp_valid = 1'b0;
    dec_is_load = ld; dec_is_store = st; dec_rf_wen = wen; ex_next_pc = npc;
    @(negedge clk);
    chk("ex_state", {29'b0, state}, 32'd2);
    chk("inst_latched", inst, data);
    exp_ir = exp_ir + 1;
    sb.push_back('{npc, wen & ~st, exp_ir});
    tick();
    dec_is_load = 1'b0; dec_is_store = 1'b0; dec_rf_wen = 1'b0; ex_next_pc = 32'hdead_beef;
    if (ld | st) begin
      n = 0;
      dmem_req_ready = 1'b0;
      for (int i = 0; i < mem_dly; i++) begin
        @(negedge clk); if (dmem_req_valid) n++;
        tick();
      end
      dmem_req_ready = 1'b1;
      @(negedge clk); if (dmem_req_valid) n++;
      chk("dmem_we", {31'b0, dmem_req_we}, {31'b0, st});
      tick();
      dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b1;
      tick();
      dmem_rsp_valid = 1'b0;
      chk("dmem_valid_cycles", n, mem_dly + 1);
    end
    @(negedge clk);
    chk("wb_retire", {31'b0, retire}, 32'd1);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rel_cyc;
    int n;
    rst = 1'b0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1234_5678;
    dec_is_load = 1'b1; dec_is_store = 1'b1; dec_rf_wen = 1'b1; ex_next_pc = 32'h0;
    dmem_req_ready = 1'b1; dmem_rsp_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_state", {29'b0, state}, 32'd0);
    chk("rst_pc", pc, 32'h8000_0000);
    chk("rst_inst", inst, 32'd0);
    chk("rst_instret", instret, 32'd0);
    chk("rst_bus_err", {31'b0, bus_err}, 32'd0);
    chk("rst_valids", {28'b0, imem_req_valid, dmem_req_valid, retire, rf_wen}, 32'd0);
    imem_rsp_valid = 1'b0; dec_is_load = 1'b0; dec_is_store = 1'b0; dec_rf_wen = 1'b0;
    dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
    tick();
    rst = 1'b1;
    rel_cyc = cyc;

    // ALU, nominal latency; retire lands in the fourth cycle after release
    do_inst(32'h8000_0000, 32'h0000_0013, 1'b0, 1'b0, 1'b1, 32'h8000_0004, 0, 0, 1'b0);
    chk("first_retire_cycle", last_ret - rel_cyc + 1, 4);
    do_inst(32'h8000_0004, 32'h0010_0093, 1'b0, 1'b0, 1'b0, 32'h8000_0008, 0, 0, 1'b0);
    chk("alu_gap", last_ret - prev_ret, 4);
    // load with dmem ready delayed 3 cycles
    do_inst(32'h8000_0008, 32'h0000_2083, 1'b1, 1'b0, 1'b1, 32'h8000_000c, 0, 3, 1'b0);
    chk("load_gap", last_ret - prev_ret, 9);
    do_inst(32'h8000_000c, 32'h0010_2023, 1'b0, 1'b1, 1'b1, 32'h8000_0100, 0, 0, 1'b0);
    chk("store_gap", last_ret - prev_ret, 6);
    // early response ignored; real response on the last allowed wait cycle
    do_inst(32'h8000_0100, 32'h00a0_0513, 1'b0, 1'b0, 1'b1, 32'h8000_0104, 15, 0, 1'b1);
    chk("late_rsp_gap", last_ret - prev_ret, 19);
    chk("late_rsp_no_err", {31'b0, bus_err}, 32'd0);

    // async reset in MEM_WAIT
    imem_req_ready = 1'b1; tick();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_3103; tick();
    imem_rsp_valid = 1'b0; dec_is_load = 1'b1; dec_rf_wen = 1'b1; ex_next_pc = 32'h8000_0108; tick();
    dec_is_load = 1'b0; dec_rf_wen = 1'b0; dmem_req_ready = 1'b1; tick();
    dmem_req_ready = 1'b0;
    #2 chk("pre_rst_mem_wait", {29'b0, state}, 32'd4);
    #1 rst = 1'b0;
    #1;
    chk("async_rst_state", {29'b0, state}, 32'd0);
    chk("async_rst_pc", pc, 32'h8000_0000);
    chk("async_rst_instret", instret, 32'd0);
    chk("async_rst_valids", {29'b0, imem_req_valid, dmem_req_valid, retire}, 32'd0);
    sb.delete();
    exp_ir = 0;
    tick(); tick();
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_fetch_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("post_rst_fetch_addr", imem_addr, 32'h8000_0000);

    // fetch response never arrives
    imem_req_ready = 1'b1; tick();
    imem_req_ready = 1'b0;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (state != 3'd1) break;
      n++;
      tick();
    end
    chk("if_wait_cycles_to_err", n, 16);
    chk("err_state", {29'b0, state}, 32'd6);
    chk("err_bus_err", {31'b0, bus_err}, 32'd1);
    imem_req_ready = 1'b1; dmem_req_ready = 1'b1; imem_rsp_valid = 1'b1; dmem_rsp_valid = 1'b1;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      if (imem_req_valid || dmem_req_valid || retire) n++;
    end
    chk("err_no_requests", n, 0);
    chk("err_sticky", {29'b0, state}, 32'd6);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
